// File: rtl/ecc_lockstep_chk.sv
// ecc_lockstep_chk: SECDED read-path checker with two lockstep decode lanes.
// Corrected data and status are registered behind a valid/ready handshake.
// Saturating error counters and a sticky fault flag feed the safety block.
// Optional macro ECC_LOCKSTEP_INJ_EN adds inj_en/inj_bit, which flip one lane1
// mask bit ahead of the compare so the comparator and counters can self-test.
//
// Code: check bit i (i < PARITY_WIDTH-1) is the XOR of the data bits whose
// Hamming position has bit i set. Data bits fill the non-power-of-two
// positions 3,5,6,7,9,... in order. The top check bit is the overall parity
// of the data and the lower check bits.
module ecc_lockstep_chk #(
    parameter int DATA_WIDTH   = 20,
    parameter int PARITY_WIDTH = 6,
    parameter int CNT_WIDTH    = 8,
    parameter int FAULT_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    input  logic                    detc_en,
    input  logic                    clr,
`ifdef ECC_LOCKSTEP_INJ_EN
    input  logic                    inj_en,
    input  logic [((DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1)-1:0] inj_bit,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    fault_sticky,
    output logic                    fault_irq
);

    localparam int SW = PARITY_WIDTH - 1;
    // Highest Hamming position in use; a syndrome above it cannot be corrected.
    localparam logic [SW-1:0] NPOS = SW'(DATA_WIDTH + SW);

    function automatic logic [DATA_WIDTH*SW-1:0] build_pos();
        logic [DATA_WIDTH*SW-1:0] t;
        int k;
        t = '0;
        k = 0;
        for (int p = 1; p < (1 << SW); p++) begin
            if (k < DATA_WIDTH && (p & (p - 1)) != 0) begin
                t[k*SW +: SW] = p[SW-1:0];
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [DATA_WIDTH*SW-1:0] POS_TBL = build_pos();

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [SW-1:0]         syn;
        logic                  ovr;
        logic [DATA_WIDTH-1:0] mask;
        logic                  sbit;
        logic                  dbit;

        // One SECDED decode lane: syndrome, overall parity, correction mask.
        always_comb begin
            syn = parity_in[SW-1:0];
            for (int k = 0; k < DATA_WIDTH; k++) begin
                if (data_in[k]) syn = syn ^ POS_TBL[k*SW +: SW];
            end
            ovr  = ^{data_in, parity_in};
            mask = '0;
            for (int k = 0; k < DATA_WIDTH; k++) begin
                mask[k] = ovr && (syn == POS_TBL[k*SW +: SW]);
            end
            sbit = ovr && (syn <= NPOS);
            dbit = (!ovr && syn != '0) || (ovr && syn > NPOS);
        end
    end

    logic [DATA_WIDTH-1:0] mask1;
`ifdef ECC_LOCKSTEP_INJ_EN
    assign mask1 = g_lane[1].mask ^ (DATA_WIDTH'(inj_en) << inj_bit);
`else
    assign mask1 = g_lane[1].mask;
`endif

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sbit_q, sbit_d, dbit_q, dbit_d, fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
    logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
    logic                  sticky_q, sticky_d, irq_q, irq_d;
    logic                  accept, mismatch, sbit_w, dbit_w, fault_w;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign mismatch = {g_lane[0].sbit, g_lane[0].dbit, g_lane[0].mask} !=
                      {g_lane[1].sbit, g_lane[1].dbit, mask1};
    assign sbit_w   = ~bypass & g_lane[0].sbit;
    assign dbit_w   = ~bypass & g_lane[0].dbit;
    assign fault_w  = ~bypass & detc_en & mismatch;

    // Next-state: output register load/hold, saturating counters, sticky, irq.
    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        sbit_d      = sbit_q;
        dbit_d      = dbit_q;
        fault_d     = fault_q;
        sbit_cnt_d  = sbit_cnt_q;
        dbit_cnt_d  = dbit_cnt_q;
        fault_cnt_d = fault_cnt_q;
        sticky_d    = sticky_q;
        irq_d       = fault_cnt_q >= CNT_WIDTH'(FAULT_THRESH);

        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = (bypass || fault_w) ? data_in : (data_in ^ g_lane[0].mask);
            sbit_d      = sbit_w;
            dbit_d      = dbit_w;
            fault_d     = fault_w;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            sbit_cnt_d  = '0;
            dbit_cnt_d  = '0;
            fault_cnt_d = '0;
            sticky_d    = 1'b0;
        end else if (accept) begin
            if (sbit_w && sbit_cnt_q != '1)   sbit_cnt_d  = sbit_cnt_q + 1'b1;
            if (dbit_w && dbit_cnt_q != '1)   dbit_cnt_d  = dbit_cnt_q + 1'b1;
            if (fault_w && fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
            if (fault_w)                      sticky_d    = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sbit_q      <= 1'b0;
            dbit_q      <= 1'b0;
            fault_q     <= 1'b0;
            sbit_cnt_q  <= '0;
            dbit_cnt_q  <= '0;
            fault_cnt_q <= '0;
            sticky_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            sbit_q      <= sbit_d;
            dbit_q      <= dbit_d;
            fault_q     <= fault_d;
            sbit_cnt_q  <= sbit_cnt_d;
            dbit_cnt_q  <= dbit_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            sticky_q    <= sticky_d;
            irq_q       <= irq_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign data_out     = data_q;
    assign sbit_err     = sbit_q;
    assign dbit_err     = dbit_q;
    assign ecc_fault    = fault_q;
    assign sbit_cnt     = sbit_cnt_q;
    assign dbit_cnt     = dbit_cnt_q;
    assign fault_cnt    = fault_cnt_q;
    assign fault_sticky = sticky_q;
    assign fault_irq    = irq_q;

endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Directed bench for ecc_lockstep_chk with default parameters.
// Inject-path checks are included when ECC_LOCKSTEP_INJ_EN is defined.
`timescale 1ns/1ps
module tb_ecc_lockstep_chk;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, bypass, detc_en, clr;
    logic [19:0] data_in, data_out;
    logic [5:0]  parity_in;
    logic        out_valid, out_ready, sbit_err, dbit_err, ecc_fault;
    logic [7:0]  sbit_cnt, dbit_cnt, fault_cnt;
    logic        fault_sticky, fault_irq;
`ifdef ECC_LOCKSTEP_INJ_EN
    logic        inj_en;
    logic [4:0]  inj_bit;
`endif

    always #5 clk = ~clk;

    ecc_lockstep_chk dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .parity_in(parity_in), .bypass(bypass),
        .detc_en(detc_en), .clr(clr),
`ifdef ECC_LOCKSTEP_INJ_EN
        .inj_en(inj_en), .inj_bit(inj_bit),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
        .fault_sticky(fault_sticky), .fault_irq(fault_irq)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference encoder: data bits at non-power-of-two positions 3,5,6,7,9...
    function automatic logic [5:0] enc(input logic [19:0] d);
        logic [5:0] p;
        int k;
        p = '0;
        k = 0;
        for (int pos = 1; pos <= 25; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < 5; i++) if (pos[i]) p[i] = p[i] ^ d[k];
                k++;
            end
        end
        p[5] = (^d) ^ (^p[4:0]);
        return p;
    endfunction

    task automatic drive(input logic [19:0] d, input logic [5:0] p, input logic byp);
        data_in   = d;
        parity_in = p;
        bypass    = byp;
        in_valid  = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [19:0] data;
        logic [19:0] dflip;
        logic [5:0]  pflip;
        logic        byp;
        logic [19:0] exp_data;
        logic        exp_s;
        logic        exp_d;
    } vec_t;

    vec_t vecs[10];
    int   es, ed;

    initial begin
        vecs[0] = '{20'hABCDE, 20'h00000, 6'h00, 1'b0, 20'hABCDE, 1'b0, 1'b0};
        vecs[1] = '{20'hABCDE, 20'h00008, 6'h00, 1'b0, 20'hABCDE, 1'b1, 1'b0};
        vecs[2] = '{20'hABCDE, 20'h00081, 6'h00, 1'b0, 20'hABC5F, 1'b0, 1'b1};
        vecs[3] = '{20'h12345, 20'h00000, 6'h04, 1'b0, 20'h12345, 1'b1, 1'b0};
        vecs[4] = '{20'h12345, 20'h00000, 6'h20, 1'b0, 20'h12345, 1'b1, 1'b0};
        vecs[5] = '{20'h00000, 20'h80000, 6'h00, 1'b0, 20'h00000, 1'b1, 1'b0};
        vecs[6] = '{20'hABCDE, 20'h00008, 6'h00, 1'b1, 20'hABCD6, 1'b0, 1'b0};
        vecs[7] = '{20'hFFFFF, 20'h00001, 6'h01, 1'b0, 20'hFFFFE, 1'b0, 1'b1};
        vecs[8] = '{20'hFFFFF, 20'h00000, 6'h00, 1'b0, 20'hFFFFF, 1'b0, 1'b0};
        vecs[9] = '{20'h5A5A5, 20'h00400, 6'h00, 1'b0, 20'h5A5A5, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; detc_en = 1'b1;
        clr = 1'b0; bypass = 1'b0; data_in = '0; parity_in = '0;
`ifdef ECC_LOCKSTEP_INJ_EN
        inj_en = 1'b0; inj_bit = '0;
`endif
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        chk("rst_flags", {sbit_err, dbit_err, ecc_fault, fault_sticky, fault_irq}, 0);
        rst = 1'b0;
        step();

        // Table of single words, one accept per cycle.
        es = 0; ed = 0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].data ^ vecs[i].dflip, enc(vecs[i].data) ^ vecs[i].pflip, vecs[i].byp);
            step();
            in_valid = 1'b0;
            if (vecs[i].exp_s) es++;
            if (vecs[i].exp_d) ed++;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
            chk($sformatf("v%0d_sbit", i), sbit_err, vecs[i].exp_s);
            chk($sformatf("v%0d_dbit", i), dbit_err, vecs[i].exp_d);
            chk($sformatf("v%0d_fault", i), ecc_fault, 0);
            chk($sformatf("v%0d_scnt", i), sbit_cnt, es);
            chk($sformatf("v%0d_dcnt", i), dbit_cnt, ed);
            chk($sformatf("v%0d_fcnt", i), fault_cnt, 0);
        end
        bypass = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_irq", fault_irq, 0);

        // clr alone: counters cleared, held data untouched.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_scnt", sbit_cnt, 0);
        chk("clr_dcnt", dbit_cnt, 0);
        chk("clr_data", data_out, 20'h5A5A5);

        // Stall: word A held while B waits, then B accepted as A drains.
        out_ready = 1'b0;
        drive(20'h11111, enc(20'h11111), 1'b0);
        step();
        chk("stall_a_valid", out_valid, 1);
        chk("stall_a_data", data_out, 20'h11111);
        drive(20'h22222 ^ 20'h00010, enc(20'h22222), 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
            step();
            chk($sformatf("stall%0d_data", i), data_out, 20'h11111);
            chk($sformatf("stall%0d_scnt", i), sbit_cnt, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("stall_b_valid", out_valid, 1);
        chk("stall_b_data", data_out, 20'h22222);
        chk("stall_b_sbit", sbit_err, 1);
        chk("stall_b_scnt", sbit_cnt, 1);
        step();
        chk("stall_drain", out_valid, 0);

        // Saturation: 300 single-bit words on top of count 1.
        drive(20'h0F0F0 ^ 20'h00080, enc(20'h0F0F0), 1'b0);
        repeat (253) step();
        chk("sat_254", sbit_cnt, 254);
        step();
        chk("sat_255", sbit_cnt, 255);
        repeat (46) step();
        chk("sat_hold", sbit_cnt, 255);
        chk("sat_data", data_out, 20'h0F0F0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_win_scnt", sbit_cnt, 0);
        chk("clr_win_sbit", sbit_err, 1);
        chk("clr_win_valid", out_valid, 1);
        step();

`ifdef ECC_LOCKSTEP_INJ_EN
        inj_en = 1'b1; inj_bit = 5'd5; detc_en = 1'b1;
        drive(20'h55555, enc(20'h55555), 1'b0);
        step();
        in_valid = 1'b0;
        chk("inj_fault", ecc_fault, 1);
        chk("inj_data", data_out, 20'h55555);
        chk("inj_fcnt", fault_cnt, 1);
        chk("inj_sticky", fault_sticky, 1);
        chk("inj_irq_lag", fault_irq, 0);
        step();
        chk("inj_irq", fault_irq, 1);
        detc_en = 1'b0;
        drive(20'h55555 ^ 20'h00020, enc(20'h55555), 1'b0);
        step();
        in_valid = 1'b0;
        chk("inj_off_fault", ecc_fault, 0);
        chk("inj_off_data", data_out, 20'h55555);
        chk("inj_off_fcnt", fault_cnt, 1);
        inj_en = 1'b0; detc_en = 1'b1;
        step();
`endif

        // Reset while a word is stalled in the output register.
        out_ready = 1'b0;
        drive(20'h33333 ^ 20'h00100, enc(20'h33333), 1'b0);
        step();
        in_valid = 1'b0;
        chk("rstmid_pre_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_scnt", sbit_cnt, 0);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_sticky", fault_sticky, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ecc_lockstep_chk.md
Name: ecc_lockstep_chk

Overview:
Pipelined, parametrised SECDED read-path checker for the FIFO ECC layer.
- Runs two identical SECDED decode lanes on each valid word and compares their results every cycle (lockstep).
- Registers the corrected data and status, with a valid/ready handshake.
- Keeps saturating error counters and sticky fault flags for the safety/status block.
- Sits between the FIFO RAM read port and the consumer.

Parameters:
DATA_WIDTH, 20, data bits per word
PARITY_WIDTH, 6, SECDED check bits; must satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH
CNT_WIDTH, 8, width of each saturating counter
FAULT_THRESH, 1, lockstep fault count at or above which fault_irq asserts

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  read word valid
in_ready  out  1  = ~out_valid | out_ready
data_in  in  DATA_WIDTH  raw data from RAM
parity_in  in  PARITY_WIDTH  stored check bits
bypass  in  1  1 = no correction; data passed through, sbit/dbit forced 0
detc_en  in  1  lockstep compare enable
clr  in  1  one-cycle pulse: clear counters and sticky flags
out_valid  out  1  output word valid
out_ready  in  1  consumer accept
data_out  out  DATA_WIDTH  corrected data
sbit_err  out  1  single-bit error corrected (qualified by out_valid)
dbit_err  out  1  uncorrectable error (qualified by out_valid)
ecc_fault  out  1  lockstep mismatch on this word (qualified by out_valid)
sbit_cnt  out  CNT_WIDTH  saturating count of sbit_err words
dbit_cnt  out  CNT_WIDTH  saturating count of dbit_err words
fault_cnt  out  CNT_WIDTH  saturating count of ecc_fault words
fault_sticky  out  1  set by any ecc_fault, held until clr
fault_irq  out  1  registered; 1 while fault_cnt >= FAULT_THRESH

Behaviour:
- Reset: all outputs 0 (out_valid, data_out, flags, counters, sticky, irq). in_ready = 1 after reset.
- Decode lanes: two instances of the team's SECDED calc core (same code and parity_in convention as the FIFO encoder). Each produces mask, sbit, dbit.
- Mismatch: any difference in {sbit, dbit, mask} between the lanes.
- Accept: a word is accepted when in_valid & in_ready. Latency is 1 cycle: out_valid rises on the edge after accept.
- Stall: while out_valid & ~out_ready, the output register holds and in_ready = 0.
- Output register load, no mismatch or detc_en = 0: data_out = data_in ^ lane0 mask; sbit/dbit from lane0.
- Output register load, mismatch and detc_en = 1: data_out = data_in (uncorrected), ecc_fault = 1; sbit/dbit still from lane0.
- Counters update only on the accept cycle. Each increments by 1 when its flag is set and saturates at all-ones (no wrap).
- fault_sticky is set on the accept cycle of a faulting word.
- clr:
  - Zeroes counters and sticky on the next edge.
  - Same-cycle clr and increment: clr wins; the word is not counted.
  - clr does not affect the pipeline data.
- fault_irq is computed from the registered fault_cnt; it lags fault_cnt by 1 cycle.
- bypass: data_out = data_in; sbit, dbit and ecc_fault forced 0; no counter updates.
- rst mid-transfer: the held word is discarded, out_valid = 0 on the next cycle.

Optional Feature:
Macro: ECC_LOCKSTEP_INJ_EN
- Defined: adds input inj_en (1 bit) and input inj_bit (clog2(DATA_WIDTH) bits).
  - While inj_en = 1, lane1 mask bit inj_bit is inverted before the compare, so every accepted non-bypass word with detc_en = 1 reports ecc_fault.
  - This is the self-test of the comparator and counters. Lane0 data path is unaffected.
- Undefined: ports absent; lanes compared unmodified.

Test Plan:
- Clean word 0xABCDE with matching parity, out_ready = 1 -> next cycle out_valid = 1, data_out = 0xABCDE, all flags 0, counters 0.
- Bit 3 of data_in flipped -> data_out = original word, sbit_err = 1, sbit_cnt = 1; two bits flipped -> dbit_err = 1, dbit_cnt = 1.
- out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, data_out held, no new word accepted; out_ready = 1 -> word consumed, next word accepted same cycle.
- Apply 300 single-bit-error words (CNT_WIDTH = 8) -> sbit_cnt = 255; pulse clr on the same cycle as an sbit accept -> sbit_cnt = 0.
- With ECC_LOCKSTEP_INJ_EN, inj_en = 1, inj_bit = 5, detc_en = 1 -> ecc_fault = 1, data_out = data_in, fault_sticky = 1, fault_irq = 1 one cycle after fault_cnt = 1. With detc_en = 0 -> corrected data, no fault.
- rst asserted while out_valid = 1 and stalled -> next cycle out_valid = 0, counters 0, in_ready = 1.
